sad_accum: RTL and testbench

SAD_ACCUM -- requirements
Module: sad_accum

---
 rtl/sad_accum_pkg.sv | 18 +
 rtl/sad_add_sat.sv | 21 ++
 rtl/sad_accum.sv | 123 ++++++++++++
 tb/tb_sad_accum.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_accum_pkg.sv
// Shared stereo-matching definitions: datapath widths and the SAD window FSM states.
package sad_accum_pkg;

  localparam int COST_W = 18;
  localparam int DISP_W = 6;
  localparam int PIX_W  = 8;

  localparam logic [COST_W-1:0] COST_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACCUM,
    ST_EMIT,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/sad_add_sat.sv
// Absolute pixel difference added onto a running SAD, clamped at the top of the cost range.
module sad_add_sat
  import sad_accum_pkg::*;
(
  input  logic [COST_W-1:0] acc,
  input  logic [PIX_W-1:0]  a,
  input  logic [PIX_W-1:0]  b,
  output logic [COST_W-1:0] next_acc
);

  logic [PIX_W-1:0]  diff;
  logic [COST_W:0]   sum;

  always_comb begin
    diff     = (a >= b) ? (a - b) : (b - a);
    // One spare bit catches the carry so the result clamps instead of wrapping.
    sum      = {1'b0, acc} + {{(COST_W + 1 - PIX_W){1'b0}}, diff};
    next_acc = sum[COST_W] ? COST_MAX : sum[COST_W-1:0];
  end

endmodule

// File: rtl/sad_accum.sv
// Per-disparity SAD accumulator: sums WIN_PIX pixel pairs per window and strobes each result
// to the downstream minimum-finder, bracketing a search with arm/publish strobes.
module sad_accum
  import sad_accum_pkg::*;
#(
  parameter int WIN_PIX = 256,
  parameter int NDISP   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_l,
  input  logic [PIX_W-1:0]  pix_r,
  output logic              pix_ready,
  output logic [COST_W-1:0] cost,
  output logic [DISP_W-1:0] disp,
  output logic              update,
  output logic              startsig,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int CNT_W = $clog2(WIN_PIX + 1);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(WIN_PIX - 1);
  localparam logic [DISP_W-1:0] LAST_DISP = DISP_W'(NDISP - 1);

  // Handshake: a pair is consumed on a rising edge where pix_valid && pix_ready;
  // pix_ready depends only on state, never on pix_valid.

  state_e              state_q, state_d;
  logic [COST_W-1:0]   acc_q, acc_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic [COST_W-1:0]   sum_nxt;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [DISP_W-1:0]   disp_cnt_q, disp_cnt_d;
  logic [DISP_W-1:0]   disp_q, disp_d;

  sad_add_sat u_add (
    .acc      (acc_q),
    .a        (pix_l),
    .b        (pix_r),
    .next_acc (sum_nxt)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pix_cnt_d  = pix_cnt_q;
    disp_cnt_d = disp_cnt_q;
    cost_d     = cost_q;
    disp_d     = disp_q;
    pix_ready  = 1'b0;
    update     = 1'b0;
    startsig   = 1'b0;
    busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        startsig   = 1'b1;
        acc_d      = '0;
        pix_cnt_d  = '0;
        disp_cnt_d = '0;
        state_d    = ST_ACCUM;
      end
      ST_ACCUM: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          acc_d     = sum_nxt;
          pix_cnt_d = pix_cnt_q + 1'b1;
          // Capture the result on the closing transfer so it is on cost/disp during EMIT.
          if (pix_cnt_q == LAST_PIX) begin
            cost_d  = sum_nxt;
            disp_d  = disp_cnt_q;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        update    = 1'b1;
        acc_d     = '0;
        pix_cnt_d = '0;
        if (disp_cnt_q < LAST_DISP) begin
          disp_cnt_d = disp_cnt_q + 1'b1;
          state_d    = ST_ACCUM;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        startsig = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cost_q     <= '0;
      pix_cnt_q  <= '0;
      disp_cnt_q <= '0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cost_q     <= cost_d;
      pix_cnt_q  <= pix_cnt_d;
      disp_cnt_q <= disp_cnt_d;
      disp_q     <= disp_d;
    end
  end

  assign cost      = cost_q;
  assign disp      = disp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sad_accum.sv
// Bench for sad_accum: three parameterisations share the stimulus bus, a scoreboard checks
// every update strobe against SAD values computed from the pixel pairs, plus a min-finder model.
module tb_sad_accum;
  import sad_accum_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [2:0] start_v   = '0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_l     = '0;
  logic [7:0] pix_r     = '0;

  logic [2:0]  rdy, upd, sts, bsy;
  logic [17:0] cst [3];
  logic [5:0]  dsp [3];
  state_e      dst [3];

  sad_accum #(.WIN_PIX(4), .NDISP(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .pix_valid(pix_valid), .pix_l(pix_l), .pix_r(pix_r),
    .pix_ready(rdy[0]), .cost(cst[0]), .disp(dsp[0]), .update(upd[0]), .startsig(sts[0]),
    .busy(bsy[0]), .dbg_state(dst[0]));

  sad_accum #(.WIN_PIX(1024), .NDISP(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_v[1]), .pix_valid(pix_valid), .pix_l(pix_l), .pix_r(pix_r),
    .pix_ready(rdy[1]), .cost(cst[1]), .disp(dsp[1]), .update(upd[1]), .startsig(sts[1]),
    .busy(bsy[1]), .dbg_state(dst[1]));

  sad_accum #(.WIN_PIX(8), .NDISP(4)) dut_m (
    .clk(clk), .rst(rst), .start(start_v[2]), .pix_valid(pix_valid), .pix_l(pix_l), .pix_r(pix_r),
    .pix_ready(rdy[2]), .cost(cst[2]), .disp(dsp[2]), .update(upd[2]), .startsig(sts[2]),
    .busy(bsy[2]), .dbg_state(dst[2]));

  logic [17:0] sa_acc, sa_out;
  logic [7:0]  sa_a, sa_b;
  sad_add_sat u_sat (.acc(sa_acc), .a(sa_a), .b(sa_b), .next_acc(sa_out));

  // ---------------- selected-instance view ----------------
  int          sel = 0;
  logic        cur_ready, cur_update, cur_startsig, cur_busy;
  logic [17:0] cur_cost;
  logic [5:0]  cur_disp;
  always_comb begin
    cur_ready    = rdy[sel];
    cur_update   = upd[sel];
    cur_startsig = sts[sel];
    cur_busy     = bsy[sel];
    cur_cost     = cst[sel];
    cur_disp     = dsp[sel];
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q [$];
  logic [23:0] exp_m;
  logic [2:0]  sel_mask;
  int n_checks = 0, n_pass = 0, upd_cnt = 0, st_cnt = 0;
  logic [17:0] last_cost;

  always @(negedge clk) begin
    sel_mask = 3'(1 << sel);
    if (cur_update) begin
      upd_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_update got cost=%0d disp=%0d required no strobe", cur_cost, cur_disp);
      end else begin
        exp_m = exp_q.pop_front();
        if ({cur_disp, cur_cost} !== exp_m)
          $display("FAIL update_result got cost=%0d disp=%0d required cost=%0d disp=%0d",
                   cur_cost, cur_disp, exp_m[17:0], exp_m[23:18]);
        else n_pass++;
      end
    end
    if (cur_startsig) st_cnt++;
    if (|(upd & sts)) begin
      n_checks++;
      $display("FAIL strobe_overlap got update=%b startsig=%b required never both", upd, sts);
    end
    if (|((upd | sts) & ~sel_mask)) begin
      n_checks++;
      $display("FAIL idle_instance_strobe got update=%b startsig=%b required only mask %b", upd, sts, sel_mask);
    end
  end

  // Downstream minimum-finder: startsig publishes the best seen and re-arms; ties keep the first.
  logic [17:0] mf_best = '1, mf_pub_cost = '0;
  logic [5:0]  mf_best_disp = '0, mf_pub_disp = '0;
  always @(negedge clk) begin
    if (sts[2]) begin
      mf_pub_cost  = mf_best;
      mf_pub_disp  = mf_best_disp;
      mf_best      = '1;
      mf_best_disp = '0;
    end else if (upd[2] && cst[2] < mf_best) begin
      mf_best      = cst[2];
      mf_best_disp = dsp[2];
    end
  end

  // ---------------- stimulus data ----------------
  logic [7:0] tab_l [4] = '{8'd10, 8'd3, 8'd0, 8'd255};
  logic [7:0] tab_r [4] = '{8'd3, 8'd10, 8'd0, 8'd0};
  int cost_tab [4] = '{40, 12, 12, 30};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [7:0] l, input logic [7:0] r, input bit rnd,
                            input bit noise, output bit ok);
    bit xfer;
    int guard;
    guard = 0;
    xfer  = 1'b0;
    do begin
      pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_l     = pix_valid ? l : 8'($urandom);
      pix_r     = pix_valid ? r : 8'($urandom);
      if (noise) start_v[sel] = 1'($urandom_range(0, 1));
      @(negedge clk);
      xfer = pix_valid && cur_ready;
      tick();
      guard++;
    end while (!xfer && guard < 100);
    start_v = '0;
    ok = xfer;
  endtask

  task automatic drive_window(input int d, input int win, input int mode, input bit rnd, input bit noise);
    int sum;
    logic [7:0] l, r;
    logic [17:0] ec;
    bit ok;
    sum = 0;
    for (int i = 0; i < win; i++) begin
      case (mode)
        1: begin
          if (d == 0) begin l = tab_l[i]; r = tab_r[i]; end
          else begin l = 8'd5; r = 8'd5; end
        end
        2: begin l = 8'd255; r = 8'd0; end
        3: begin
          if (i == 0) begin l = 8'(cost_tab[d]); r = 8'd0; end
          else begin l = 8'($urandom); r = l; end
        end
        default: begin l = 8'($urandom); r = 8'($urandom); end
      endcase
      sum += (l > r) ? (int'(l) - int'(r)) : (int'(r) - int'(l));
      drive_pair(l, r, rnd, noise, ok);
      if (!ok) begin
        n_checks++;
        $display("FAIL transfer_timeout got no transfer in 100 cycles required pair %0d of disp %0d", i, d);
      end
    end
    ec = (sum > 262143) ? 18'h3FFFF : 18'(sum);
    exp_q.push_back({6'(d), ec});
    last_cost = ec;
    @(negedge clk);
    n_checks++;
    if (cur_update !== 1'b1) $display("FAIL update_latency got update=%b required 1 one cycle after last transfer", cur_update);
    else n_pass++;
    tick();
  endtask

  task automatic start_search(input int s);
    sel = s;
    start_v[s] = 1'b1;
    tick();
    start_v = '0;
    @(negedge clk);
    n_checks++;
    if (cur_startsig !== 1'b1 || cur_busy !== 1'b1)
      $display("FAIL arm_strobe got startsig=%b busy=%b required 1 1", cur_startsig, cur_busy);
    else n_pass++;
    tick();
  endtask

  task automatic run_search(input int s, input int nd, input int win, input int mode,
                            input bit rnd, input bit noise);
    int u0, s0, guard;
    sel = s;
    pix_valid = 1'b1;
    pix_l = 8'($urandom);
    pix_r = 8'($urandom);
    repeat (3) tick();
    u0 = upd_cnt;
    s0 = st_cnt;
    start_search(s);
    for (int d = 0; d < nd; d++) drive_window(d, win, mode, rnd, noise);
    pix_valid = 1'b1;
    pix_l = 8'($urandom);
    pix_r = 8'($urandom);
    @(negedge clk);
    n_checks++;
    if (cur_startsig !== 1'b1) $display("FAIL flush_strobe got startsig=%b required 1", cur_startsig);
    else n_pass++;
    guard = 0;
    tick();
    while (cur_busy !== 1'b0 && guard < 8) begin tick(); guard++; end
    n_checks++;
    if (cur_busy !== 1'b0) $display("FAIL return_idle got busy=%b required 0", cur_busy);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (upd_cnt - u0 !== nd) $display("FAIL update_count got %0d required %0d", upd_cnt - u0, nd);
    else n_pass++;
    n_checks++;
    if (st_cnt - s0 !== 2) $display("FAIL startsig_count got %0d required 2", st_cnt - s0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL pending_expected got %0d entries required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (cur_cost !== last_cost || cur_disp !== 6'(nd - 1))
      $display("FAIL output_hold got cost=%0d disp=%0d required cost=%0d disp=%0d",
               cur_cost, cur_disp, last_cost, nd - 1);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rdy[i] !== 1'b0 || upd[i] !== 1'b0 || sts[i] !== 1'b0 || bsy[i] !== 1'b0 ||
          cst[i] !== 18'd0 || dsp[i] !== 6'd0 || dst[i] !== ST_IDLE)
        $display("FAIL reset_state inst %0d got rdy=%b upd=%b sts=%b busy=%b cost=%0d disp=%0d required all 0",
                 i, rdy[i], upd[i], sts[i], bsy[i], cst[i], dsp[i]);
      else n_pass++;
    end
    tick();
    rst = 1'b0;
    pix_valid = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (bsy !== 3'b000 || st_cnt !== 0) $display("FAIL idle_after_reset got busy=%b startsig_count=%0d required 0 0", bsy, st_cnt);
    else n_pass++;
  endtask

  task automatic test_example();
    run_search(0, 2, 4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_sat_add();
    int s;
    logic [17:0] e;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0: {sa_acc, sa_a, sa_b} = {18'h3FFF0, 8'd255, 8'd0};
        1: {sa_acc, sa_a, sa_b} = {18'h3FFFF, 8'd0, 8'd1};
        2: {sa_acc, sa_a, sa_b} = {18'h00000, 8'd0, 8'd255};
        3: {sa_acc, sa_a, sa_b} = {18'h3FF00, 8'd200, 8'd55};
        default: begin
          sa_acc = (i % 2 == 1) ? 18'(18'h3FF00 + $urandom_range(0, 255)) : 18'($urandom);
          sa_a   = 8'($urandom);
          sa_b   = 8'($urandom);
        end
      endcase
      #1;
      s = int'(sa_acc) + ((sa_a > sa_b) ? (int'(sa_a) - int'(sa_b)) : (int'(sa_b) - int'(sa_a)));
      e = (s > 262143) ? 18'h3FFFF : 18'(s);
      n_checks++;
      if (sa_out !== e) $display("FAIL sat_add acc=%0d a=%0d b=%0d got %0d required %0d", sa_acc, sa_a, sa_b, sa_out, e);
      else n_pass++;
    end
  endtask

  task automatic test_big_window();
    run_search(1, 1, 1024, 2, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_search(2, 4, 8, 0, 1'b1, 1'b0);
    run_search(0, 2, 4, 0, 1'b1, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    run_search(0, 2, 4, 0, 1'b0, 1'b1);
    run_search(2, 4, 8, 0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int u1, s1;
    bit ok;
    sel = 0;
    start_search(0);
    drive_window(0, 4, 0, 1'b0, 1'b0);
    drive_pair(8'($urandom), 8'($urandom), 1'b0, 1'b0, ok);
    drive_pair(8'($urandom), 8'($urandom), 1'b0, 1'b0, ok);
    rst = 1'b1;
    #1;
    n_checks++;
    if (rdy[0] !== 1'b0 || upd[0] !== 1'b0 || sts[0] !== 1'b0 || bsy[0] !== 1'b0 ||
        cst[0] !== 18'd0 || dsp[0] !== 6'd0 || dst[0] !== ST_IDLE)
      $display("FAIL mid_reset got rdy=%b upd=%b sts=%b busy=%b cost=%0d disp=%0d required all 0",
               rdy[0], upd[0], sts[0], bsy[0], cst[0], dsp[0]);
    else n_pass++;
    u1 = upd_cnt;
    s1 = st_cnt;
    repeat (2) tick();
    rst = 1'b0;
    pix_valid = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (upd_cnt !== u1 || st_cnt !== s1 || bsy[0] !== 1'b0)
      $display("FAIL after_reset_quiet got updates=%0d startsigs=%0d busy=%b required %0d %0d 0",
               upd_cnt, st_cnt, bsy[0], u1, s1);
    else n_pass++;
    run_search(0, 2, 4, 0, 1'b1, 1'b0);
  endtask

  task automatic test_min_finder();
    run_search(2, 4, 8, 3, 1'b1, 1'b0);
    n_checks++;
    if (mf_pub_cost !== 18'd12 || mf_pub_disp !== 6'd1)
      $display("FAIL min_finder got cost=%0d disp=%0d required cost=12 disp=1", mf_pub_cost, mf_pub_disp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_example();
    test_sat_add();
    test_big_window();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid();
    test_min_finder();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion required finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
